// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default
// frame geometry and the line levels that delimit a frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the rx_clk domain and flags the
// idle-to-start transition used to open a frame.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic rx_clk,
    input  logic rst,
    input  logic line,
    output logic line_sync,
    output logic fall_edge
);

    logic meta;
    logic prev;

    // Flops reset to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            meta      <= IDLE_LEVEL;
            line_sync <= IDLE_LEVEL;
            prev      <= IDLE_LEVEL;
        end else begin
            meta      <= line;
            line_sync <= meta;
            prev      <= line_sync;
        end
    end

    assign fall_edge = (prev == IDLE_LEVEL) && (line_sync == START_LEVEL);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH bits LSB first, optional even
// parity, one stop bit. Each frame ends with a one-cycle rx_valid pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                  rx_clk,
    input  logic                  rst,
    input  logic                  rx_enable,
    input  logic                  parity_enable,
    input  logic                  rx_serial_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [SW-1:0] MID_START   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);

    logic                  line_sync;
    logic                  fall_edge;
    state_t                state;
    logic [SW-1:0]         sample_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_en_q;
    logic                  perr;
    logic                  sample_tick;

    uart_rx_sync u_sync (
        .rx_clk    (rx_clk),
        .rst       (rst),
        .line      (rx_serial_in),
        .line_sync (line_sync),
        .fall_edge (fall_edge)
    );

    // Once centred on the start bit, every later sample lands one full bit period on.
    assign sample_tick = (sample_cnt == SAMPLE_LAST);

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            par_en_q      <= 1'b0;
            perr          <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!rx_enable) begin
                state      <= IDLE;
                busy       <= 1'b0;
                sample_cnt <= '0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall_edge) begin
                            state      <= START;
                            busy       <= 1'b1;
                            sample_cnt <= '0;
                            par_en_q   <= parity_enable;
                        end
                    end
                    START: begin
                        if (sample_cnt == MID_START) begin
                            sample_cnt <= '0;
                            if (line_sync == START_LEVEL) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (sample_tick) begin
                            sample_cnt <= '0;
                            shift      <= (shift >> 1) | (DATA_WIDTH'(line_sync) << (DATA_WIDTH - 1));
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                perr    <= 1'b0;
                                state   <= par_en_q ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (sample_tick) begin
                            sample_cnt <= '0;
                            perr       <= line_sync ^ (^shift);
                            state      <= STOP;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (sample_tick) begin
                            // Back to IDLE at mid-stop so a following start edge is seen in time.
                            sample_cnt    <= '0;
                            state         <= IDLE;
                            busy          <= 1'b0;
                            rx_data       <= shift;
                            parity_error  <= perr;
                            framing_error <= (line_sync != STOP_LEVEL);
                            rx_valid      <= 1'b1;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as they are driven and
// checked (data, status, latency) when rx_valid pulses.
module tb_uart_rx;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic       rx_clk = 1'b0;
    logic       rst;
    logic       rx_enable;
    logic       parity_enable;
    logic       rx_serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   valid_cycles[$];
    exp_t sb[$];
    logic [7:0] last_data = 8'h00;

    uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .rx_clk        (rx_clk),
        .rst           (rst),
        .rx_enable     (rx_enable),
        .parity_enable (parity_enable),
        .rx_serial_in  (rx_serial_in),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every rx_valid pulse must match the oldest queued frame.
    always @(negedge rx_clk) begin
        if (!rst && rx_valid) begin
            valid_cycles.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("parity_error", 32'(parity_error), 32'(e.perr));
                check("framing_error", 32'(framing_error), 32'(e.ferr));
                check("latency", 32'(cyc), 32'(e.cyc));
                last_data = e.data;
            end
        end
    end

    task automatic do_abort(input int mode);
        check("abort_busy_before", 32'(busy), 32'd1);
        if (mode == 1) begin
            rx_enable = 1'b0;
            @(negedge rx_clk);
            check("abort_en_busy", 32'(busy), 32'd0);
            check("abort_en_data_held", 32'(rx_data), 32'(last_data));
            rx_enable = 1'b1;
        end else begin
            rst = 1'b1;
            #1;
            check("abort_rst_busy", 32'(busy), 32'd0);
            check("abort_rst_data", 32'(rx_data), 32'd0);
            check("abort_rst_flags", 32'({rx_valid, parity_error, framing_error}), 32'd0);
            @(negedge rx_clk);
            rst       = 1'b0;
            last_data = 8'h00;
        end
        rx_serial_in = 1'b1;
        repeat (48) @(negedge rx_clk);
        check("abort_idle", 32'(busy), 32'd0);
    endtask

    // Called on a negedge; each line bit is held for 16 rx_clk cycles.
    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_bit,
                              input logic stop_bit, input int abort);
        logic [10:0] bits;
        int nb;
        exp_t e;
        if (use_par) begin
            bits = {stop_bit, par_bit, d, 1'b0};
            nb   = 11;
        end else begin
            bits = {1'b1, stop_bit, d, 1'b0};
            nb   = 10;
        end
        parity_enable = use_par;
        if (abort == 0) begin
            e.data = d;
            e.perr = use_par ? (par_bit ^ (^d)) : 1'b0;
            e.ferr = ~stop_bit;
            e.cyc  = cyc + (use_par ? 171 : 155);
            sb.push_back(e);
        end
        for (int b = 0; b < nb; b++) begin
            rx_serial_in = bits[b];
            for (int c = 0; c < 16; c++) begin
                if (abort != 0 && b == 4 && c == 8) begin
                    do_abort(abort);
                    return;
                end
                @(negedge rx_clk);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge rx_clk);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        rx_enable     = 1'b1;
        parity_enable = 1'b0;
        rx_serial_in  = 1'b1;
        repeat (2) @(negedge rx_clk);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_flags", 32'({rx_valid, parity_error, framing_error, busy}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge rx_clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Good frame with correct even parity
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0);
        drain("drain_a5");

        // Wrong parity, then correct parity clears the flag
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 0);
        drain("drain_parity");

        // Stop bit low, then a held-low line must not retrigger
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
        drain("drain_framing");
        repeat (300) @(negedge rx_clk);
        check("break_busy", 32'(busy), 32'd0);
        check("break_data_held", 32'({rx_data, framing_error}), 32'({8'h3C, 1'b1}));
        rx_serial_in = 1'b1;
        repeat (32) @(negedge rx_clk);

        // Short glitch is rejected as a false start
        rx_serial_in = 1'b0;
        repeat (4) @(negedge rx_clk);
        rx_serial_in = 1'b1;
        check("glitch_busy_rise", 32'(busy), 32'd1);
        repeat (10) @(negedge rx_clk);
        check("glitch_busy_fall", 32'(busy), 32'd0);
        repeat (20) @(negedge rx_clk);

        // Aborts mid data bit 3, each followed by a clean frame
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 2);
        check("post_reset_data", 32'({rx_data, rx_valid, parity_error, framing_error, busy}), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 0);
        drain("drain_5a");

        // Back-to-back frames with parity
        valid_cycles.delete();
        send_frame(8'h12, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'h34, 1'b1, 1'b1, 1'b1, 0);
        drain("drain_b2b");
        check("b2b_pulses", 32'(valid_cycles.size()), 32'd2);
        if (valid_cycles.size() == 2)
            check("b2b_spacing", 32'(valid_cycles[1] - valid_cycles[0]), 32'd176);
        repeat (20) @(negedge rx_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
